// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - ALU control types and requester-side bus of the shared-ALU arbiter
package alu_pkg;
  typedef enum logic [3:0] {
    nop_, add_, sub_, and_, or_, xor_, sll_, srl_, sra_, lt_, eq_, ne_, ge_
  } alu_op_t;

  typedef struct packed {
    alu_op_t op;
    logic    is_signed;
  } ALU_sig;
endpackage

interface alu_arbiter_if #(
  parameter int DATA_W = 32
);
  import alu_pkg::*;

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  ALU_sig            req_ctrl0;
  ALU_sig            req_ctrl1;
  logic [DATA_W-1:0] req_in1_0;
  logic [DATA_W-1:0] req_in1_1;
  logic [DATA_W-1:0] req_in2_0;
  logic [DATA_W-1:0] req_in2_1;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_branch;

  modport master (
    output req_valid, req_ctrl0, req_ctrl1, req_in1_0, req_in1_1, req_in2_0, req_in2_1,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_branch
  );

  modport slave (
    input  req_valid, req_ctrl0, req_ctrl1, req_in1_0, req_in1_1, req_in2_0, req_in2_1,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_branch
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port arbiter in front of the shared combinational ALU
// Grants one requester per free slot and returns the ALU result through a one-entry response register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  alu_arbiter_if.slave      bus,
  output ALU_sig            alu_ctrl,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_branch_flag
);

  typedef enum logic {IDLE, RESP} state_t;

  state_t            state;
  state_t            state_nxt;
  logic              rsp_owner;
  logic              last_grant;
  logic              slot_free;
  logic              accept;
  logic              gnt;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_branch_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // In RESP the owner's valid is always high, so its ready alone frees the slot.
  always_comb begin
    slot_free = (state == IDLE) || bus.rsp_ready[rsp_owner];
    if (bus.req_valid == 2'b11) begin
      gnt = RR_EN ? ~last_grant : 1'b0;
    end else begin
      gnt = bus.req_valid[1];
    end
    accept    = !rst && slot_free && (|bus.req_valid);
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RESP;
      RESP: if (bus.rsp_ready[rsp_owner]) state_nxt = accept ? RESP : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = 2'b00;
    bus.rsp_valid = 2'b00;
    alu_ctrl      = '{op: nop_, is_signed: 1'b0};
    alu_in1       = '0;
    alu_in2       = '0;
    if (accept) begin
      bus.req_ready[gnt] = 1'b1;
      alu_ctrl = gnt ? bus.req_ctrl1 : bus.req_ctrl0;
      alu_in1  = gnt ? bus.req_in1_1 : bus.req_in1_0;
      alu_in2  = gnt ? bus.req_in2_1 : bus.req_in2_0;
    end
    if (state == RESP) begin
      bus.rsp_valid[rsp_owner] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_data_q   <= '0;
      rsp_branch_q <= 1'b0;
      rsp_owner    <= 1'b0;
      last_grant   <= 1'b1;
    end else if (accept) begin
      rsp_data_q   <= alu_out;
      rsp_branch_q <= alu_branch_flag;
      rsp_owner    <= gnt;
      last_grant   <= gnt;
    end
  end

  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_branch = rsp_branch_q;

  a_req_ready_onehot: assert property (@(posedge clk) $onehot0(bus.req_ready));
  a_rsp_valid_onehot: assert property (@(posedge clk) $onehot0(bus.rsp_valid));
  a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
    (|(bus.rsp_valid & ~bus.rsp_ready)) |=>
      ($stable(bus.rsp_data) && $stable(bus.rsp_branch) && $stable(bus.rsp_valid)));

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter (round-robin and fixed-priority)
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_W(32)) bus ();
  alu_arbiter_if #(.DATA_W(32)) bus_fp ();

  ALU_sig      alu_ctrl, fp_alu_ctrl;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic [31:0] fp_alu_in1, fp_alu_in2, fp_alu_out;
  logic        alu_branch_flag, fp_alu_branch_flag;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [32:0] alu_model(input ALU_sig c, input logic [31:0] a, input logic [31:0] b);
    logic lt;
    lt = c.is_signed ? ($signed(a) < $signed(b)) : (a < b);
    case (c.op)
      add_:    return {1'b0, a + b};
      sub_:    return {1'b0, a - b};
      xor_:    return {1'b0, a ^ b};
      lt_:     return {lt, 31'b0, lt};
      default: return 33'b0;
    endcase
  endfunction

  always_comb {alu_branch_flag, alu_out} = alu_model(alu_ctrl, alu_in1, alu_in2);
  always_comb {fp_alu_branch_flag, fp_alu_out} = alu_model(fp_alu_ctrl, fp_alu_in1, fp_alu_in2);

  alu_arbiter #(.DATA_W(32), .RR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .alu_ctrl(alu_ctrl), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_branch_flag(alu_branch_flag)
  );

  alu_arbiter #(.DATA_W(32), .RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .bus(bus_fp),
    .alu_ctrl(fp_alu_ctrl), .alu_in1(fp_alu_in1), .alu_in2(fp_alu_in2),
    .alu_out(fp_alu_out), .alu_branch_flag(fp_alu_branch_flag)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic p0(input alu_op_t op, input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.req_ctrl0 = '{op: op, is_signed: s};
    bus.req_in1_0 = a;
    bus.req_in2_0 = b;
  endtask

  task automatic p1(input alu_op_t op, input logic s, input logic [31:0] a, input logic [31:0] b);
    bus.req_ctrl1 = '{op: op, is_signed: s};
    bus.req_in1_1 = a;
    bus.req_in2_1 = b;
  endtask

  task automatic clear();
    bus.req_valid    = 2'b00;
    bus.rsp_ready    = 2'b00;
    bus_fp.req_valid = 2'b00;
    bus_fp.rsp_ready = 2'b00;
    p0(nop_, 1'b0, 32'h0, 32'h0);
    p1(nop_, 1'b0, 32'h0, 32'h0);
    bus_fp.req_ctrl0 = '{op: nop_, is_signed: 1'b0};
    bus_fp.req_ctrl1 = '{op: nop_, is_signed: 1'b0};
    bus_fp.req_in1_0 = 32'h0;
    bus_fp.req_in2_0 = 32'h0;
    bus_fp.req_in1_1 = 32'h0;
    bus_fp.req_in2_1 = 32'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with both ports requesting: nothing may be accepted
    rst = 1'b1;
    clear();
    bus.req_valid    = 2'b11;
    bus_fp.req_valid = 2'b11;
    mid();
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_fp_req_ready", 32'(bus_fp.req_ready), 32'h0);
    tick();
    mid();
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_data", bus.rsp_data, 32'h0);
    chk("rst_rsp_branch", 32'(bus.rsp_branch), 32'h0);
    tick();
    rst = 1'b0;
    clear();

    // Single op on port 0
    p0(add_, 1'b0, 32'd5, 32'd7);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b01;
    mid();
    chk("t1_req_ready", 32'(bus.req_ready), 32'h1);
    chk("t1_alu_op", 32'(alu_ctrl.op), 32'(add_));
    chk("t1_alu_in1", alu_in1, 32'd5);
    chk("t1_alu_in2", alu_in2, 32'd7);
    tick();
    bus.req_valid = 2'b00;
    mid();
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_rsp_data", bus.rsp_data, 32'd12);
    chk("t1_rsp_branch", 32'(bus.rsp_branch), 32'h0);
    chk("t1_idle_op", 32'(alu_ctrl.op), 32'(nop_));
    chk("t1_idle_in1", alu_in1, 32'h0);
    tick();
    mid();
    chk("t1_back_idle", 32'(bus.rsp_valid), 32'h0);
    tick();

    // Tie with round-robin
    do_reset();
    p0(sub_, 1'b0, 32'd10, 32'd3);
    p1(xor_, 1'b0, 32'hF0, 32'h0F);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    mid();
    chk("t2_first_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b10;
    mid();
    chk("t2_rsp0_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t2_rsp0_data", bus.rsp_data, 32'd7);
    chk("t2_second_grant", 32'(bus.req_ready), 32'h2);
    chk("t2_p1_alu_in1", alu_in1, 32'hF0);
    tick();
    bus.req_valid = 2'b11;
    mid();
    chk("t2_rsp1_valid", 32'(bus.rsp_valid), 32'h2);
    chk("t2_rsp1_data", bus.rsp_data, 32'hFF);
    chk("t2_alt_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    mid();
    chk("t2_rsp0b_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t2_rsp0b_data", bus.rsp_data, 32'd7);
    tick();

    // Fixed priority instance: port 1 starves while port 0 requests
    do_reset();
    bus_fp.req_ctrl0 = '{op: add_, is_signed: 1'b0};
    bus_fp.req_in1_0 = 32'd1;
    bus_fp.req_in2_0 = 32'd1;
    bus_fp.req_ctrl1 = '{op: add_, is_signed: 1'b0};
    bus_fp.req_in1_1 = 32'd100;
    bus_fp.req_in2_1 = 32'd0;
    bus_fp.req_valid = 2'b11;
    bus_fp.rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("t3_fp_port0_wins", 32'(bus_fp.req_ready), 32'h1);
      tick();
    end
    bus_fp.req_valid = 2'b10;
    mid();
    chk("t3_fp_rsp0_data", bus_fp.rsp_data, 32'd2);
    chk("t3_fp_port1_grant", 32'(bus_fp.req_ready), 32'h2);
    tick();
    bus_fp.req_valid = 2'b00;
    mid();
    chk("t3_fp_rsp1_valid", 32'(bus_fp.rsp_valid), 32'h2);
    chk("t3_fp_rsp1_data", bus_fp.rsp_data, 32'd100);
    tick();

    // Backpressure on port 1 with port 0 waiting; non-owner ready ignored
    do_reset();
    p1(lt_, 1'b1, 32'hFFFF_FFFF, 32'd1);
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b00;
    mid();
    chk("t4_grant", 32'(bus.req_ready), 32'h2);
    tick();
    p0(add_, 1'b0, 32'd20, 32'd22);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("t4_hold_valid", 32'(bus.rsp_valid), 32'h2);
      chk("t4_hold_data", bus.rsp_data, 32'd1);
      chk("t4_hold_branch", 32'(bus.rsp_branch), 32'h1);
      chk("t4_wait_ready", 32'(bus.req_ready), 32'h0);
      tick();
    end
    bus.rsp_ready = 2'b10;
    mid();
    chk("t4_drain_grant", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b01;
    mid();
    chk("t4_p0_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t4_p0_data", bus.rsp_data, 32'd42);
    chk("t4_p0_branch", 32'(bus.rsp_branch), 32'h0);
    tick();

    // Back-to-back on port 0
    p0(add_, 1'b0, 32'd1, 32'd1);
    bus.req_valid = 2'b01;
    bus.rsp_ready = 2'b01;
    mid();
    chk("t5_accept", 32'(bus.req_ready), 32'h1);
    tick();
    p0(add_, 1'b0, 32'd2, 32'd2);
    mid();
    chk("t5_valid_1", 32'(bus.rsp_valid), 32'h1);
    chk("t5_data_1", bus.rsp_data, 32'd2);
    chk("t5_accept_2", 32'(bus.req_ready), 32'h1);
    tick();
    p0(add_, 1'b0, 32'd3, 32'd3);
    mid();
    chk("t5_valid_2", 32'(bus.rsp_valid), 32'h1);
    chk("t5_data_2", bus.rsp_data, 32'd4);
    tick();
    bus.req_valid = 2'b00;
    mid();
    chk("t5_valid_3", 32'(bus.rsp_valid), 32'h1);
    chk("t5_data_3", bus.rsp_data, 32'd6);
    tick();
    mid();
    chk("t5_idle", 32'(bus.rsp_valid), 32'h0);
    tick();

    // Reset while a response is held
    p1(add_, 1'b0, 32'd9, 32'd9);
    bus.req_valid = 2'b10;
    bus.rsp_ready = 2'b00;
    mid();
    chk("t6_grant", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 2'b00;
    mid();
    chk("t6_held_valid", 32'(bus.rsp_valid), 32'h2);
    chk("t6_held_data", bus.rsp_data, 32'd18);
    tick();
    rst = 1'b1;
    p0(add_, 1'b0, 32'd1, 32'd2);
    p1(add_, 1'b0, 32'd3, 32'd4);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    mid();
    chk("t6_rst_req_ready", 32'(bus.req_ready), 32'h0);
    tick();
    rst = 1'b0;
    mid();
    chk("t6_after_rst_valid", 32'(bus.rsp_valid), 32'h0);
    chk("t6_after_rst_data", bus.rsp_data, 32'h0);
    chk("t6_after_rst_branch", 32'(bus.rsp_branch), 32'h0);
    chk("t6_first_tie", 32'(bus.req_ready), 32'h1);
    tick();
    bus.req_valid = 2'b00;
    mid();
    chk("t6_first_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t6_first_rsp_data", bus.rsp_data, 32'd3);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
